// File: rtl/fifo_rd_stream_if.sv
// Signal bundle between the FIFO read port, the read-to-stream converter and the
// downstream stream consumer. The master modport is the converter's view.
interface fifo_rd_stream_if #(
  parameter int DW = 8
);
  logic          fifo_e;
  logic [DW-1:0] fifo_dout;
  logic          fifo_re;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    input  fifo_e, fifo_dout, m_ready,
    output fifo_re, m_data, m_valid
  );

  modport slave (
    output fifo_e, fifo_dout, m_ready,
    input  fifo_re, m_data, m_valid
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns a synchronous FIFO's one-cycle-latency read port into a registered
// valid/ready stream, using a 2-entry skid buffer plus an in-flight flag.
module fifo_rd_stream #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic [CW-1:0] xfer_cnt,
  fifo_rd_stream_if.master bus
);

  logic [1:0]    occ;
  logic          infl;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;

  logic          pop;
  logic          capture;
  logic [2:0]    level;
  logic          fifo_re_c;
  logic [1:0]    occ_nxt;

  // occ + infl never exceeds 2, so the read request only looks at the words
  // still owed to the consumer after this cycle's transfer.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    pop       = (occ != 2'd0) && bus.m_ready;
    capture   = infl && !flush;
    level     = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    fifo_re_c = !rst && !bus.fifo_e && !flush && (level < 3'd2);
    occ_nxt   = occ;
    if (flush) begin
      occ_nxt = 2'd0;
    end else begin
      case ({capture, pop})
        2'b10:   occ_nxt = occ + 2'd1;
        2'b01:   occ_nxt = occ - 2'd1;
        default: occ_nxt = occ;
      endcase
    end
  end

  assign bus.fifo_re = fifo_re_c;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      infl     <= 1'b0;
      head_q   <= '0;
      xfer_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      occ  <= occ_nxt;
      infl <= fifo_re_c;
      if (pop && !flush) begin
        xfer_cnt <= xfer_cnt + CW'(1);
      end
      // Head refills from the tail on a pop, or straight from the FIFO when the
      // arriving word becomes the oldest one.
      if (!flush && pop && (occ == 2'd2)) begin
        head_q <= tail_q;
      end else if (capture && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        head_q <= bus.fifo_dout;
      end
    end
  end

  // NOTE: the tail slot is not reset; it is only read while occ says it holds a word.
  always_ff @(posedge clk) begin
    if (capture && (occ == 2'd1) && !pop) begin
      tail_q <= bus.fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + randomized bench for fifo_rd_stream: a queue-based FIFO feeds the
// block and a word-level model predicts the stream, read requests and counter.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] xfer_cnt;

  fifo_rd_stream_if #(.DW(DW)) bus ();

  fifo_rd_stream #(.DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .xfer_cnt (xfer_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src_q[$];  // words still inside the FIFO
  logic [DW-1:0] exp_q[$];  // words read from the FIFO, owed to the consumer
  int exp_cnt = 0;
  bit infl_m  = 1'b0;
  int cyc, re_cycles, valid_cycles, first_re, first_valid, n_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; re_cycles = 0; valid_cycles = 0;
    first_re = -1; first_valid = -1; n_xfer = 0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
    bus.fifo_e = (src_q.size() == 0);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdy, input bit fl = 1'b0);
    bit exp_valid, exp_pop, exp_re, re_s;
    int owed;
    bus.m_ready = rdy;
    flush       = fl;
    bus.fifo_e  = (src_q.size() == 0);
    #1;
    owed      = exp_q.size();
    exp_valid = (owed - int'(infl_m)) > 0;
    exp_pop   = exp_valid && rdy;
    exp_re    = (src_q.size() != 0) && !fl && ((owed - int'(exp_pop)) < 2);
    check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    check("fifo_re", 32'(bus.fifo_re), 32'(exp_re));
    check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    if (exp_valid) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
    re_s = bus.fifo_re;
    if (re_s) begin
      re_cycles++;
      if (first_re < 0) first_re = cyc;
    end
    if (bus.m_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fl) begin
      exp_q.delete();
    end else if (exp_pop) begin
      exp_q.delete(0);
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      n_xfer++;
    end
    infl_m = re_s;
    if (re_s && (src_q.size() != 0)) begin
      bus.fifo_dout = src_q.pop_front();
      exp_q.push_back(bus.fifo_dout);
    end else begin
      bus.fifo_dout = DW'($urandom);
    end
    bus.fifo_e = (src_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic reset_model();
    exp_q.delete();
    infl_m  = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    bus.m_ready   = 1'b0;
    bus.fifo_dout = '0;
    src_q = {8'h11, 8'h22, 8'h33};
    bus.fifo_e = 1'b0;

    // Reset state, with a non-empty FIFO already presented.
    #2;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic order and latency.
    clear_stats();
    for (int i = 0; i < 7; i++) step(1'b1);
    check("basic_first_re", 32'(first_re), 32'd0);
    check("basic_latency", 32'(first_valid - first_re), 32'd2);
    check("basic_valid_cycles", 32'(valid_cycles), 32'd3);
    check("basic_cnt", 32'(xfer_cnt), 32'd3);

    // Backpressure: only two words may be requested while stalled.
    clear_stats();
    push_words(5);
    for (int i = 0; i < 10; i++) step(1'b0);
    check("bp_re_cycles", 32'(re_cycles), 32'd2);
    check("bp_valid_held", 32'(valid_cycles), 32'd8);
    for (int i = 0; i < 12; i++) step(1'b1);
    check("bp_drained", 32'(exp_q.size() + src_q.size()), 32'd0);
    check("bp_xfers", 32'(n_xfer), 32'd5);
    check("bp_cnt", 32'(xfer_cnt), 32'd8);

    // Empty boundary: a single word.
    clear_stats();
    push_words(1);
    for (int i = 0; i < 6; i++) step(1'b1);
    check("empty_re_cycles", 32'(re_cycles), 32'd1);
    check("empty_valid_cycles", 32'(valid_cycles), 32'd1);

    // Flush with one buffered and one in-flight word, consumer ready.
    push_words(5);
    step(1'b0);
    step(1'b0);
    check("flush_owed", 32'(exp_q.size()), 32'd2);
    step(1'b1, 1'b1);
    check("flush_cnt", 32'(xfer_cnt), 32'd9);
    clear_stats();
    for (int i = 0; i < 8; i++) step(1'b1);
    check("flush_after_valid", 32'(valid_cycles), 32'd3);
    check("flush_after_cnt", 32'(xfer_cnt), 32'd12);

    // Reset between edges while streaming.
    push_words(6);
    for (int i = 0; i < 4; i++) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_fifo_re", 32'(bus.fifo_re), 32'd0);
    check("mid_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("mid_rst_m_data", 32'(bus.m_data), 32'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1);
    check("mid_rst_drained", 32'(exp_q.size() + src_q.size()), 32'd0);

    // Counter wrap: 17 transfers from reset with random backpressure.
    rst = 1'b1;
    #1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    push_words(17);
    for (int i = 0; i < 300 && (exp_q.size() + src_q.size()) != 0; i++) step(1'($urandom_range(0, 1)));
    check("wrap_done", 32'(exp_q.size() + src_q.size()), 32'd0);
    check("wrap_xfers", 32'(n_xfer), 32'd17);
    check("wrap_cnt", 32'(xfer_cnt), 32'd1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) push_words(int'($urandom_range(1, 3)));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 60 && (exp_q.size() + src_q.size()) != 0; i++) step(1'b1);
    check("rand_drained", 32'(exp_q.size() + src_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
